// File: rtl/regfile_gclk_req.sv
// Per-register gated-clock request generator for the register file, with an
// idle-timeout sleep handshake toward the clock controller and write stalling while asleep.
module regfile_gclk_req #(
    parameter int unsigned NUM_REGS    = 32,
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned IDLE_CYCLES = 8
) (
    input  logic                in_clk,
    input  logic                in_rst_n,
    input  logic                in_wr_en,
    input  logic [ADDR_W-1:0]   in_wr_addr,
    input  logic                in_all_idle,
    input  logic                in_sleep_ack,
    output logic [NUM_REGS-1:0] out_gclk,
    output logic                out_sleep_req,
    output logic                out_stall
);

    localparam int unsigned      CNT_W    = $clog2(IDLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(IDLE_CYCLES);

    typedef enum logic [1:0] {
        ACTIVE,
        REQ,
        SLEEP,
        WAKE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    idle_cnt;
    logic [CNT_W-1:0]    idle_cnt_nxt;
    logic [NUM_REGS-1:0] gclk_nxt;
    logic                wr_accept;

    always_comb begin
        state_nxt = state;
        wr_accept = 1'b0;
        out_stall = 1'b0;
        case (state)
            ACTIVE: begin
                wr_accept = in_wr_en;
                if (!in_wr_en && in_all_idle && (idle_cnt == IDLE_MAX)) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                // A write always beats a simultaneous acknowledge.
                wr_accept = in_wr_en;
                if (in_wr_en) begin
                    state_nxt = ACTIVE;
                end else if (in_sleep_ack) begin
                    state_nxt = SLEEP;
                end
            end
            SLEEP: begin
                out_stall = in_wr_en;
                if (in_wr_en) begin
                    state_nxt = WAKE;
                end
            end
            WAKE: begin
                out_stall = in_wr_en;
                if (!in_sleep_ack) begin
                    state_nxt = ACTIVE;
                end
            end
            default: state_nxt = ACTIVE;
        endcase
    end

    // Counter only runs while staying in ACTIVE; every other path parks it at zero.
    always_comb begin
        idle_cnt_nxt = '0;
        if (!in_wr_en && (state == ACTIVE) && (state_nxt == ACTIVE)) begin
            idle_cnt_nxt = (idle_cnt == IDLE_MAX) ? idle_cnt : idle_cnt + 1'b1;
        end
    end

    // Bit 0 is excluded since x0 is hardwired; out-of-range addresses match nothing.
    always_comb begin
        gclk_nxt = '0;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            gclk_nxt[i] = wr_accept && (32'(in_wr_addr) == i);
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state         <= ACTIVE;
            idle_cnt      <= '0;
            out_gclk      <= '0;
            out_sleep_req <= 1'b0;
        end else begin
            state         <= state_nxt;
            idle_cnt      <= idle_cnt_nxt;
            out_gclk      <= gclk_nxt;
            out_sleep_req <= (state_nxt == REQ) || (state_nxt == SLEEP);
        end
    end

endmodule

// File: tb/tb_regfile_gclk_req.sv
// Bench for regfile_gclk_req: directed vector table, hand-written handshake
// sequences, and a randomized run against a behavioural reference model.
module tb_regfile_gclk_req;

    localparam int unsigned NR   = 32;
    localparam int unsigned AW   = 6;
    localparam int unsigned IDLE = 8;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          all_idle;
    logic          sleep_ack;
    logic [NR-1:0] gclk;
    logic          sleep_req;
    logic          stall;

    int checks   = 0;
    int failures = 0;

    regfile_gclk_req #(
        .NUM_REGS   (NR),
        .ADDR_W     (AW),
        .IDLE_CYCLES(IDLE)
    ) dut (
        .in_clk      (clk),
        .in_rst_n    (rst_n),
        .in_wr_en    (wr_en),
        .in_wr_addr  (wr_addr),
        .in_all_idle (all_idle),
        .in_sleep_ack(sleep_ack),
        .out_gclk    (gclk),
        .out_sleep_req(sleep_req),
        .out_stall   (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        bit          wr;
        logic [5:0]  addr;
        bit          idle;
        bit          ack;
        logic [31:0] e_gclk;
        bit          e_req;
        bit          e_stall;
    } vec_t;

    vec_t vecs[6];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endfunction

    task automatic set_in(input bit wr, input logic [AW-1:0] a, input bit idle, input bit ack);
        wr_en     = wr;
        wr_addr   = a;
        all_idle  = idle;
        sleep_ack = ack;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT one cycle into SLEEP, ack still high, at posedge+1.
    task automatic goto_sleep();
        bit reached;
        reached = 1'b0;
        set_in(1'b1, 6'd1, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 30; i++) begin
            set_in(1'b0, 6'd0, 1'b1, 1'b0);
            #2;
            if (sleep_req === 1'b1) begin
                reached = 1'b1;
                break;
            end
            tick();
        end
        chk("reach_req", 32'(reached), 32'd1);
        set_in(1'b0, 6'd0, 1'b1, 1'b1);
        tick();
        set_in(1'b0, 6'd0, 1'b1, 1'b1);
        #2;
        chk("sleep_req_in_sleep", 32'(sleep_req), 32'd1);
        chk("gclk_in_sleep", gclk, 32'd0);
        tick();
    endtask

    // Reference model: spec-level modes and an idle counter.
    localparam int M_ACTIVE = 0, M_REQ = 1, M_SLEEP = 2, M_WAKE = 3;
    int          m_mode;
    int          m_idle;
    logic [31:0] m_gclk;

    task automatic model_step(input bit wr, input int a, input bit idle, input bit ack);
        int  nmode;
        bit  acc;
        acc    = wr && (m_mode == M_ACTIVE || m_mode == M_REQ);
        m_gclk = (acc && a >= 1 && a < int'(NR)) ? (32'd1 << a) : 32'd0;
        nmode  = m_mode;
        case (m_mode)
            M_ACTIVE: if (m_idle == int'(IDLE) && !wr && idle) nmode = M_REQ;
            M_REQ:    if (wr) nmode = M_ACTIVE; else if (ack) nmode = M_SLEEP;
            M_SLEEP:  if (wr) nmode = M_WAKE;
            default:  if (!ack) nmode = M_ACTIVE;
        endcase
        if (wr || m_mode != M_ACTIVE || nmode != M_ACTIVE) m_idle = 0;
        else if (m_idle < int'(IDLE)) m_idle = m_idle + 1;
        m_mode = nmode;
    endtask

    initial begin
        int stall_cnt;
        int hits;

        vecs[0] = '{1'b1, 6'd5,  1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 6'd0,  1'b0, 1'b0, 32'h0000_0020, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 6'd31, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 6'd40, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 6'd0,  1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 6'd0,  1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0};

        rst_n = 1'b0;
        set_in(1'b1, 6'd5, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_gclk", gclk, 32'd0);
        chk("reset_sleep_req", 32'(sleep_req), 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            set_in(vecs[i].wr, vecs[i].addr, vecs[i].idle, vecs[i].ack);
            #2;
            chk($sformatf("vec%0d_gclk", i), gclk, vecs[i].e_gclk);
            chk($sformatf("vec%0d_req", i), 32'(sleep_req), 32'(vecs[i].e_req));
            chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
            tick();
        end

        // Idle timeout: write at cycle 0, all_idle from cycle 2, request at cycle 10.
        for (int c = 0; c <= 10; c++) begin
            set_in(c == 0, 6'd1, c >= 2, 1'b0);
            #2;
            chk($sformatf("idle_req_c%0d", c), 32'(sleep_req), 32'(c == 10));
            if (c < 10) tick();
        end

        // Write and ack collide in REQ: write wins.
        set_in(1'b1, 6'd3, 1'b1, 1'b1);
        #2;
        chk("abort_stall_now", 32'(stall), 32'd0);
        tick();
        set_in(1'b0, 6'd0, 1'b0, 1'b0);
        #2;
        chk("abort_req_next", 32'(sleep_req), 32'd0);
        chk("abort_gclk_next", gclk, 32'h0000_0008);
        chk("abort_stall_next", 32'(stall), 32'd0);
        tick();

        for (int c = 0; c < 25; c++) begin
            set_in(c == 0, 6'd1, 1'b0, 1'b0);
            #2;
            chk($sformatf("busy_noreq_c%0d", c), 32'(sleep_req), 32'd0);
            tick();
        end

        // Held write through SLEEP/WAKE, ack dropped three cycles after the write.
        goto_sleep();
        stall_cnt = 0;
        hits      = 0;
        for (int i = 0; i < 10; i++) begin
            set_in(i <= 4, 6'd7, 1'b1, i < 3);
            #2;
            if (stall === 1'b1) stall_cnt++;
            if (gclk === 32'h0000_0080) hits++;
            if (i == 1) chk("wake_req_fall", 32'(sleep_req), 32'd0);
            if (i == 5) chk("wake_gclk7", gclk, 32'h0000_0080);
            tick();
        end
        chk("wake_stall_cycles", stall_cnt, 4);
        chk("wake_gclk7_once", hits, 1);

        // Reset mid-handshake with a stalled write.
        goto_sleep();
        set_in(1'b1, 6'd7, 1'b1, 1'b1);
        #2;
        chk("pre_rst_stall", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_gclk", gclk, 32'd0);
        chk("rst_sleep_req", 32'(sleep_req), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_in(1'b1, 6'd2, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 6'd0, 1'b0, 1'b0);
        #2;
        chk("post_rst_gclk2", gclk, 32'h0000_0004);
        tick();

        // A write every 7 cycles keeps the counter short of the limit.
        for (int c = 0; c < 70; c++) begin
            set_in((c % 7) == 0, AW'($urandom_range(1, 31)), 1'b1, 1'b0);
            #2;
            chk($sformatf("stream_noreq_c%0d", c), 32'(sleep_req), 32'd0);
            tick();
        end

        // Randomized run against the reference model.
        rst_n = 1'b0;
        set_in(1'b0, 6'd0, 1'b0, 1'b0);
        #2;
        rst_n  = 1'b1;
        m_mode = M_ACTIVE;
        m_idle = 0;
        m_gclk = 32'd0;
        tick();
        for (int c = 0; c < 1500; c++) begin
            bit          r_wr;
            logic [5:0]  r_addr;
            bit          r_idle;
            bit          r_ack;
            r_wr   = ($urandom % 10) == 0;
            r_addr = 6'($urandom % 64);
            r_idle = ($urandom % 8) != 0;
            r_ack  = $urandom % 2;
            set_in(r_wr, r_addr, r_idle, r_ack);
            #2;
            chk($sformatf("rnd%0d_gclk", c), gclk, m_gclk);
            chk($sformatf("rnd%0d_req", c), 32'(sleep_req), 32'(m_mode == M_REQ || m_mode == M_SLEEP));
            chk($sformatf("rnd%0d_stall", c), 32'(stall),
                32'(r_wr && (m_mode == M_SLEEP || m_mode == M_WAKE)));
            model_step(r_wr, int'(r_addr), r_idle, r_ack);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
